health_manager: RTL

//   Consumes hit_p1_to_p2 / hit_p2_to_p1 from the combinational hit resolver and turns them into game state.

---
 rtl/fighter_pkg.sv | 31 +++
 rtl/player_vitals.sv | 66 ++++++
 rtl/health_manager.sv | 109 ++++++++++
 3 files changed

// File: rtl/fighter_pkg.sv
// Shared encodings for the fighting-game datapath: player actions, round state and winner.
package fighter_pkg;

  typedef enum logic [2:0] {
    ACT_IDLE    = 3'b000,
    ACT_MOVE    = 3'b001,
    ACT_JUMP    = 3'b010,
    ACT_BLOCK   = 3'b011,
    ACT_ATTACK1 = 3'b100,
    ACT_ATTACK2 = 3'b101,
    ACT_HIT     = 3'b111
  } action_e;

  typedef enum logic [1:0] {
    RS_IDLE  = 2'b00,
    RS_FIGHT = 2'b01,
    RS_KO    = 2'b10
  } round_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  function automatic logic is_attack(input logic [2:0] act);
    return (act == ACT_ATTACK1) || (act == ACT_ATTACK2);
  endfunction

endpackage

// File: rtl/player_vitals.sv
// One player's health, hitstun and invulnerability state, plus the decision whether an incoming hit lands.
module player_vitals
  import fighter_pkg::*;
#(
  parameter int HP_WIDTH       = 8,
  parameter int MAX_HP         = 100,
  parameter int HITSTUN_FRAMES = 20,
  parameter int INVULN_FRAMES  = 30,
  parameter int CNT_WIDTH      = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                reload_i,
  input  logic                fight_i,
  input  logic                hit_i,
  input  logic                atk_valid_i,
  input  logic                frame_tick_i,
  input  logic [HP_WIDTH-1:0] damage_i,
  output logic [HP_WIDTH-1:0] health_o,
  output logic [HP_WIDTH-1:0] health_next_o,
  output logic                hitstun_o
);

  logic [HP_WIDTH-1:0]  health_q, health_d;
  logic [CNT_WIDTH-1:0] hitstun_q, hitstun_d;
  logic [CNT_WIDTH-1:0] invuln_q, invuln_d;
  logic                 accept;

  assign accept = fight_i && hit_i && atk_valid_i && (invuln_q == '0);

  // Priority: round reload, then a landed hit (which overrides the frame decrement).
  always_comb begin
    health_d  = health_q;
    hitstun_d = hitstun_q;
    invuln_d  = invuln_q;
    if (reload_i) begin
      health_d  = HP_WIDTH'(MAX_HP);
      hitstun_d = '0;
      invuln_d  = '0;
    end else if (accept) begin
      health_d  = (health_q > damage_i) ? (health_q - damage_i) : '0;
      hitstun_d = CNT_WIDTH'(HITSTUN_FRAMES);
      invuln_d  = CNT_WIDTH'(INVULN_FRAMES);
    end else if (frame_tick_i) begin
      if (hitstun_q != '0) hitstun_d = hitstun_q - CNT_WIDTH'(1);
      if (invuln_q != '0)  invuln_d  = invuln_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      health_q  <= HP_WIDTH'(MAX_HP);
      hitstun_q <= '0;
      invuln_q  <= '0;
    end else begin
      health_q  <= health_d;
      hitstun_q <= hitstun_d;
      invuln_q  <= invuln_d;
    end
  end

  assign health_o      = health_q;
  assign health_next_o = health_d;
  assign hitstun_o     = (hitstun_q != '0);

endmodule

// File: rtl/health_manager.sv
// Turns resolver hit levels into health, hitstun and round outcome; owns the round FSM and winner.
module health_manager
  import fighter_pkg::*;
#(
  parameter int HP_WIDTH       = 8,
  parameter int MAX_HP         = 100,
  parameter int DMG_ATK1       = 8,
  parameter int DMG_ATK2       = 15,
  parameter int HITSTUN_FRAMES = 20,
  parameter int INVULN_FRAMES  = 30,
  parameter int CNT_WIDTH      = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                round_start,
  input  logic                hit_p1_to_p2,
  input  logic                hit_p2_to_p1,
  input  logic [2:0]          p1_action,
  input  logic [2:0]          p2_action,
  output logic [HP_WIDTH-1:0] p1_health,
  output logic [HP_WIDTH-1:0] p2_health,
  output logic                p1_hitstun,
  output logic                p2_hitstun,
  output logic [1:0]          round_state,
  output logic [1:0]          winner,
  output logic                ko_pulse
);

  round_state_e        state_q, state_d;
  winner_e             winner_q, winner_d;
  logic                ko_pulse_q, ko_pulse_d;
  logic [HP_WIDTH-1:0] p1_health_next, p2_health_next;
  logic                fight;

  function automatic logic [HP_WIDTH-1:0] damage_for(input logic [2:0] act);
    if (act == ACT_ATTACK1) return HP_WIDTH'(DMG_ATK1);
    if (act == ACT_ATTACK2) return HP_WIDTH'(DMG_ATK2);
    return '0;
  endfunction

  assign fight = (state_q == RS_FIGHT);

  player_vitals #(
    .HP_WIDTH(HP_WIDTH), .MAX_HP(MAX_HP), .HITSTUN_FRAMES(HITSTUN_FRAMES),
    .INVULN_FRAMES(INVULN_FRAMES), .CNT_WIDTH(CNT_WIDTH)
  ) u_p1_vitals (
    .clk(clk), .rst(rst), .reload_i(round_start), .fight_i(fight),
    .hit_i(hit_p2_to_p1), .atk_valid_i(is_attack(p2_action)),
    .frame_tick_i(frame_tick), .damage_i(damage_for(p2_action)),
    .health_o(p1_health), .health_next_o(p1_health_next), .hitstun_o(p1_hitstun)
  );

  player_vitals #(
    .HP_WIDTH(HP_WIDTH), .MAX_HP(MAX_HP), .HITSTUN_FRAMES(HITSTUN_FRAMES),
    .INVULN_FRAMES(INVULN_FRAMES), .CNT_WIDTH(CNT_WIDTH)
  ) u_p2_vitals (
    .clk(clk), .rst(rst), .reload_i(round_start), .fight_i(fight),
    .hit_i(hit_p1_to_p2), .atk_valid_i(is_attack(p1_action)),
    .frame_tick_i(frame_tick), .damage_i(damage_for(p1_action)),
    .health_o(p2_health), .health_next_o(p2_health_next), .hitstun_o(p2_hitstun)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RS_IDLE;
    else     state_q <= state_d;
  end

  // KO looks at post-update health so it becomes visible together with the health reaching 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RS_IDLE:  if (round_start) state_d = RS_FIGHT;
      RS_FIGHT: begin
        if (round_start) state_d = RS_FIGHT;
        else if ((p1_health_next == '0) || (p2_health_next == '0)) state_d = RS_KO;
      end
      RS_KO:    if (round_start) state_d = RS_FIGHT;
      default:  state_d = RS_IDLE;
    endcase
  end

  always_comb begin
    ko_pulse_d = (state_q == RS_FIGHT) && (state_d == RS_KO);
    winner_d   = winner_q;
    if (round_start) begin
      winner_d = WIN_NONE;
    end else if (ko_pulse_d) begin
      if ((p1_health_next == '0) && (p2_health_next == '0)) winner_d = WIN_DRAW;
      else if (p2_health_next == '0)                        winner_d = WIN_P1;
      else                                                  winner_d = WIN_P2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      winner_q   <= WIN_NONE;
      ko_pulse_q <= 1'b0;
    end else begin
      winner_q   <= winner_d;
      ko_pulse_q <= ko_pulse_d;
    end
  end

  assign round_state = state_q;
  assign winner      = winner_q;
  assign ko_pulse    = ko_pulse_q;

endmodule
